// File: rtl/reg_rename_pkg.sv
// Shared sizes, types and helpers for the register-rename block.
package reg_rename_pkg;

  localparam int unsigned N_ARCH = 64;
  localparam int unsigned N_PHYS = 128;
  localparam int unsigned LA     = $clog2(N_ARCH);
  localparam int unsigned LP     = $clog2(N_PHYS);

  // Free list holds every preg not in the reset map; capacity must be a power of two.
  localparam int unsigned FL_CAP = N_PHYS - N_ARCH;
  localparam int unsigned FL_PW  = $clog2(FL_CAP) + 1;  // index plus wrap bit

  typedef logic [LA-1:0]             areg_t;
  typedef logic [LP-1:0]             preg_t;
  typedef logic [FL_PW-1:0]          fl_ptr_t;
  typedef logic [N_ARCH-1:0][LP-1:0] map_t;

  typedef struct packed {
    map_t    map;
    fl_ptr_t head;
  } ckpt_t;

  // Identity map: arch i lives in phys i after reset.
  function automatic map_t map_reset();
    map_t m;
    for (int i = 0; i < N_ARCH; i++) begin
      m[i] = preg_t'(i);
    end
    return m;
  endfunction

  // Phys register held in free-list slot idx after reset.
  function automatic preg_t fl_reset_entry(input int unsigned idx);
    return preg_t'(N_ARCH + idx);
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers: multi-pop from head, multi-push at tail,
// head restore for branch recovery.
module rename_free_list
  import reg_rename_pkg::*;
#(
  parameter int unsigned POP_W  = 2,
  parameter int unsigned PUSH_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [FL_PW-1:0]     pop_cnt_i,
  input  logic [PUSH_W-1:0]    push_en_i,
  input  logic [PUSH_W*LP-1:0] push_pd_i,
  input  logic                 restore_i,
  input  logic [FL_PW-1:0]     restore_head_i,
  output logic [FL_PW-1:0]     head_o,
  output logic [POP_W*LP-1:0]  pop_pd_o,
  output logic [FL_PW-1:0]     count_o
);

  localparam int unsigned IW = FL_PW - 1;

  preg_t   mem_q [FL_CAP];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t wr_ptr [PUSH_W];

  // Pushes pack densely from tail in port order; head either restores or advances.
  always_comb begin
    tail_d = tail_q;
    for (int k = 0; k < PUSH_W; k++) begin
      wr_ptr[k] = tail_d;
      if (push_en_i[k]) begin
        tail_d = tail_d + fl_ptr_t'(1);
      end
    end
    head_d = restore_i ? restore_head_i : head_q + pop_cnt_i;
  end

  for (genvar g = 0; g < POP_W; g++) begin : g_pop
    fl_ptr_t rd_ptr;
    assign rd_ptr                = head_q + fl_ptr_t'(g);
    assign pop_pd_o[g*LP +: LP] = mem_q[rd_ptr[IW-1:0]];
  end

  // Reset fills the list with the non-architectural pregs; tail sits one full lap ahead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(FL_CAP);
      for (int i = 0; i < FL_CAP; i++) begin
        mem_q[i] <= fl_reset_entry(i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int k = 0; k < PUSH_W; k++) begin
        if (push_en_i[k]) begin
          mem_q[wr_ptr[k][IW-1:0]] <= push_pd_i[k*LP +: LP];
        end
      end
    end
  end

  assign head_o  = head_q;
  assign count_o = tail_q - head_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (tail_d - head_d) <= fl_ptr_t'(FL_CAP));

endmodule

// File: rtl/reg_rename.sv
// Register renaming: arch->phys map, busy bits, free list and branch checkpoints.
module reg_rename
  import reg_rename_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned WRITE_W = 2,
  parameter int unsigned N_CKPT  = 4,
  localparam int unsigned LC     = $clog2(N_CKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ISSUE_W-1:0]    i_valid,
  input  logic [ISSUE_W*LA-1:0] i_rs1,
  input  logic [ISSUE_W*LA-1:0] i_rs2,
  input  logic [ISSUE_W*LA-1:0] i_rd,
  input  logic [ISSUE_W-1:0]    i_rd_en,
  input  logic [ISSUE_W-1:0]    i_br,
  output logic                  i_ready,
  output logic [ISSUE_W*LP-1:0] o_ps1,
  output logic [ISSUE_W*LP-1:0] o_ps2,
  output logic [ISSUE_W-1:0]    o_rs1_rdy,
  output logic [ISSUE_W-1:0]    o_rs2_rdy,
  output logic [ISSUE_W*LP-1:0] o_pd,
  output logic [ISSUE_W*LP-1:0] o_old_pd,
  output logic [ISSUE_W*LC-1:0] o_ckpt_id,
  input  logic [WRITE_W-1:0]    w_en,
  input  logic [WRITE_W*LP-1:0] w_pd,
  input  logic [ISSUE_W-1:0]    c_en,
  input  logic [ISSUE_W*LP-1:0] c_old_pd,
  input  logic                  c_br_ok,
  input  logic [LC-1:0]         c_br_id,
  input  logic                  flush,
  input  logic [LC-1:0]         flush_id,
  output logic [LP:0]           free_cnt
);

  map_t              map_q, map_w, ck_map;
  logic [N_PHYS-1:0] busy_q, wb_clr, alloc_set;
  ckpt_t             ckpt_q [N_CKPT];
  logic [LC:0]       ck_head_q, ck_head_d, ck_tail_q, ck_tail_d;
  logic [LC-1:0]     ck_keep;
  logic [N_ARCH-1:0] grp_wr;

  fl_ptr_t               fl_head, fl_cnt, n_alloc, ck_fl_head, fl_pop_cnt;
  logic [ISSUE_W*LP-1:0] fl_pop_pd;
  logic [ISSUE_W-1:0]    push_en;
  logic                  any_br, ckpt_free, accept;

  areg_t         rs1 [ISSUE_W], rs2 [ISSUE_W], rd [ISSUE_W];
  preg_t         fl_pd [ISSUE_W], ps1 [ISSUE_W], ps2 [ISSUE_W], pd [ISSUE_W], old_pd [ISSUE_W];
  preg_t         wpd [WRITE_W];
  logic [LC-1:0] ck_id [ISSUE_W];

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    assign rs1[g]                 = i_rs1[g*LA +: LA];
    assign rs2[g]                 = i_rs2[g*LA +: LA];
    assign rd[g]                  = i_rd[g*LA +: LA];
    assign fl_pd[g]               = fl_pop_pd[g*LP +: LP];
    assign push_en[g]             = c_en[g] & (c_old_pd[g*LP +: LP] != '0);
    assign o_ps1[g*LP +: LP]      = ps1[g];
    assign o_ps2[g*LP +: LP]      = ps2[g];
    assign o_pd[g*LP +: LP]       = pd[g];
    assign o_old_pd[g*LP +: LP]   = old_pd[g];
    assign o_ckpt_id[g*LC +: LC]  = ck_id[g];
  end

  for (genvar g = 0; g < WRITE_W; g++) begin : g_wb
    assign wpd[g] = w_pd[g*LP +: LP];
  end

  // Pregs completing this cycle: clear busy and bypass to readers.
  always_comb begin
    wb_clr = '0;
    for (int j = 0; j < WRITE_W; j++) begin
      if (w_en[j] && wpd[j] != '0) begin
        wb_clr[wpd[j]] = 1'b1;
      end
    end
  end

  // Rename slots in program order against a running copy of the map.
  always_comb begin
    map_w      = map_q;
    grp_wr     = '0;
    alloc_set  = '0;
    n_alloc    = '0;
    ck_map     = map_q;
    ck_fl_head = fl_head;
    any_br     = 1'b0;
    for (int s = 0; s < ISSUE_W; s++) begin
      ps1[s]       = map_w[rs1[s]];
      ps2[s]       = map_w[rs2[s]];
      // A source produced earlier in this group is never ready yet.
      o_rs1_rdy[s] = (rs1[s] == '0) | (~grp_wr[rs1[s]] & (~busy_q[ps1[s]] | wb_clr[ps1[s]]));
      o_rs2_rdy[s] = (rs2[s] == '0) | (~grp_wr[rs2[s]] & (~busy_q[ps2[s]] | wb_clr[ps2[s]]));
      pd[s]        = '0;
      old_pd[s]    = '0;
      ck_id[s]     = '0;
      if (i_valid[s] && i_rd_en[s] && rd[s] != '0) begin
        for (int k = 0; k < ISSUE_W; k++) begin
          if (fl_ptr_t'(k) == n_alloc) begin
            pd[s] = fl_pd[k];
          end
        end
        old_pd[s]         = map_w[rd[s]];
        map_w[rd[s]]      = pd[s];
        grp_wr[rd[s]]     = 1'b1;
        alloc_set[pd[s]]  = 1'b1;
        n_alloc           = n_alloc + fl_ptr_t'(1);
      end
      if (i_valid[s] && i_br[s]) begin
        any_br     = 1'b1;
        ck_map     = map_w;
        ck_fl_head = fl_head + n_alloc;
        ck_id[s]   = ck_tail_q[LC-1:0];
      end
    end
  end

  assign ckpt_free  = (ck_tail_q - ck_head_q) != (LC+1)'(N_CKPT);
  assign i_ready    = ~rst & ~flush & (fl_cnt >= n_alloc) & (~any_br | ckpt_free);
  assign accept     = i_ready & (|i_valid);
  assign fl_pop_cnt = accept ? n_alloc : '0;
  assign ck_keep    = flush_id - ck_head_q[LC-1:0];

  // Checkpoint queue: resolve releases the oldest, flush drops flush_id and younger.
  always_comb begin
    ck_head_d = ck_head_q + (LC+1)'(c_br_ok);
    ck_tail_d = ck_tail_q;
    if (flush) begin
      ck_tail_d = ck_head_q + {1'b0, ck_keep};
    end else if (accept && any_br) begin
      ck_tail_d = ck_tail_q + (LC+1)'(1);
    end
  end

  // Map, busy bits and checkpoint pointers; allocation wins over a same-preg completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      map_q     <= map_reset();
      busy_q    <= '0;
      ck_head_q <= '0;
      ck_tail_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wb_clr) | (accept ? alloc_set : '0);
      if (flush) begin
        map_q <= ckpt_q[flush_id].map;
      end else if (accept) begin
        map_q <= map_w;
      end
      ck_head_q <= ck_head_d;
      ck_tail_q <= ck_tail_d;
    end
  end

  // Checkpoint payload; only meaningful while its slot is live, so no reset.
  always_ff @(posedge clk) begin
    if (accept && any_br) begin
      ckpt_q[ck_tail_q[LC-1:0]] <= '{map: ck_map, head: ck_fl_head};
    end
  end

  rename_free_list #(
    .POP_W (ISSUE_W),
    .PUSH_W(ISSUE_W)
  ) u_free_list (
    .clk_i         (clk),
    .rst_i         (rst),
    .pop_cnt_i     (fl_pop_cnt),
    .push_en_i     (push_en),
    .push_pd_i     (c_old_pd),
    .restore_i     (flush),
    .restore_head_i(ckpt_q[flush_id].head),
    .head_o        (fl_head),
    .pop_pd_o      (fl_pop_pd),
    .count_o       (fl_cnt)
  );

  assign free_cnt = (LP+1)'(fl_cnt);

  a_one_branch: assert property (@(posedge clk) disable iff (rst) $onehot0(i_valid & i_br));
  a_br_ok_oldest: assert property (@(posedge clk) disable iff (rst)
    c_br_ok |-> (c_br_id == ck_head_q[LC-1:0]) && (ck_tail_q != ck_head_q));
  a_br_ok_flush: assert property (@(posedge clk) disable iff (rst)
    !(c_br_ok && flush && c_br_id == flush_id));

endmodule

// File: tb/tb_reg_rename.sv
// Directed bench for reg_rename with hand-computed expectations.
module tb_reg_rename;

  localparam int LA = 6;
  localparam int LP = 7;
  localparam int LC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      i_valid, i_rd_en, i_br, i_ready_unused;
  logic [2*LA-1:0] i_rs1, i_rs2, i_rd;
  logic            i_ready;
  logic [2*LP-1:0] o_ps1, o_ps2, o_pd, o_old_pd;
  logic [1:0]      o_rs1_rdy, o_rs2_rdy;
  logic [2*LC-1:0] o_ckpt_id;
  logic [1:0]      w_en, c_en;
  logic [2*LP-1:0] w_pd, c_old_pd;
  logic            c_br_ok, flush;
  logic [LC-1:0]   c_br_id, flush_id;
  logic [LP:0]     free_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_rename #(
    .ISSUE_W(2),
    .WRITE_W(2),
    .N_CKPT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_rd     (i_rd),
    .i_rd_en  (i_rd_en),
    .i_br     (i_br),
    .i_ready  (i_ready),
    .o_ps1    (o_ps1),
    .o_ps2    (o_ps2),
    .o_rs1_rdy(o_rs1_rdy),
    .o_rs2_rdy(o_rs2_rdy),
    .o_pd     (o_pd),
    .o_old_pd (o_old_pd),
    .o_ckpt_id(o_ckpt_id),
    .w_en     (w_en),
    .w_pd     (w_pd),
    .c_en     (c_en),
    .c_old_pd (c_old_pd),
    .c_br_ok  (c_br_ok),
    .c_br_id  (c_br_id),
    .flush    (flush),
    .flush_id (flush_id),
    .free_cnt (free_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_valid  = '0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_rd     = '0;
    i_rd_en  = '0;
    i_br     = '0;
    w_en     = '0;
    w_pd     = '0;
    c_en     = '0;
    c_old_pd = '0;
    c_br_ok  = 1'b0;
    c_br_id  = '0;
    flush    = 1'b0;
    flush_id = '0;
  endtask

  task automatic slot(input int s, input logic [LA-1:0] a1, input logic [LA-1:0] a2,
                      input logic [LA-1:0] d, input logic den, input logic br);
    i_valid[s]         = 1'b1;
    i_rs1[s*LA +: LA]  = a1;
    i_rs2[s*LA +: LA]  = a2;
    i_rd[s*LA +: LA]   = d;
    i_rd_en[s]         = den;
    i_br[s]            = br;
  endtask

  function automatic logic [LP-1:0] ps1_of(input int s);
    return o_ps1[s*LP +: LP];
  endfunction
  function automatic logic [LP-1:0] ps2_of(input int s);
    return o_ps2[s*LP +: LP];
  endfunction
  function automatic logic [LP-1:0] pd_of(input int s);
    return o_pd[s*LP +: LP];
  endfunction
  function automatic logic [LP-1:0] old_of(input int s);
    return o_old_pd[s*LP +: LP];
  endfunction

  // Reset with stray activity on the inputs; it must all be ignored.
  task automatic do_reset();
    clr();
    rst = 1'b1;
    slot(0, 0, 0, 5, 1'b1, 1'b0);
    c_en     = 2'b01;
    c_old_pd = 14'd9;
    tick();
    check_eq("ready_in_rst", i_ready, 0);
    tick();
    rst = 1'b0;
    clr();
    #1;
    check_eq("rst_free_cnt", free_cnt, 64);
  endtask

  initial begin
    i_ready_unused = '0;
    clr();
    do_reset();

    // Single rename of r5.
    slot(0, 5, 0, 5, 1'b1, 1'b0);
    #1;
    check_eq("t1_ready", i_ready, 1);
    check_eq("t1_ps1", ps1_of(0), 5);
    check_eq("t1_rdy1", o_rs1_rdy[0], 1);
    check_eq("t1_ps2_r0", ps2_of(0), 0);
    check_eq("t1_rdy2_r0", o_rs2_rdy[0], 1);
    check_eq("t1_pd", pd_of(0), 64);
    check_eq("t1_old", old_of(0), 5);
    tick();
    clr();
    #1;
    check_eq("t1_free", free_cnt, 63);

    // Intra-group dependency and same-rd chain.
    do_reset();
    slot(0, 0, 0, 3, 1'b1, 1'b0);
    slot(1, 3, 0, 3, 1'b1, 1'b0);
    #1;
    check_eq("t2_pd0", pd_of(0), 64);
    check_eq("t2_old0", old_of(0), 3);
    check_eq("t2_ps1_s1", ps1_of(1), 64);
    check_eq("t2_rdy1_s1", o_rs1_rdy[1], 0);
    check_eq("t2_pd1", pd_of(1), 65);
    check_eq("t2_old1", old_of(1), 64);
    tick();
    clr();
    slot(0, 3, 0, 0, 1'b0, 1'b0);
    #1;
    check_eq("t2_map3", ps1_of(0), 65);
    check_eq("t2_busy65", o_rs1_rdy[0], 0);
    check_eq("t2_free", free_cnt, 62);

    // Write-back bypass, then the cleared busy bit.
    w_en        = 2'b10;
    w_pd[13:7]  = 7'd65;
    #1;
    check_eq("t3_bypass", o_rs1_rdy[0], 1);
    tick();
    clr();
    slot(0, 3, 0, 0, 1'b0, 1'b0);
    #1;
    check_eq("t3_after_wb", o_rs1_rdy[0], 1);
    tick();

    // Checkpoint, younger allocations, flush.
    do_reset();
    slot(0, 0, 0, 10, 1'b1, 1'b1);
    #1;
    check_eq("t4_br_pd", pd_of(0), 64);
    check_eq("t4_ckpt_id", o_ckpt_id[1:0], 0);
    tick();
    clr();
    slot(0, 0, 0, 11, 1'b1, 1'b0);
    slot(1, 0, 0, 10, 1'b1, 1'b0);
    #1;
    check_eq("t4_old_r10", old_of(1), 64);
    tick();
    clr();
    slot(0, 0, 0, 12, 1'b1, 1'b0);
    tick();
    clr();
    #1;
    check_eq("t4_free_pre", free_cnt, 60);
    flush    = 1'b1;
    flush_id = 2'd0;
    slot(0, 0, 0, 13, 1'b1, 1'b0);
    #1;
    check_eq("t4_flush_blocks", i_ready, 0);
    tick();
    clr();
    #1;
    check_eq("t4_free_post", free_cnt, 63);
    slot(0, 10, 11, 14, 1'b1, 1'b0);
    #1;
    check_eq("t4_map10", ps1_of(0), 64);
    check_eq("t4_busy64", o_rs1_rdy[0], 0);
    check_eq("t4_map11", ps2_of(0), 11);
    check_eq("t4_rdy11", o_rs2_rdy[0], 1);
    check_eq("t4_reuse65", pd_of(0), 65);
    check_eq("t4_old14", old_of(0), 14);
    tick();

    // Drain the free list, then refill with one commit.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      clr();
      slot(0, 0, 0, 1, 1'b1, 1'b0);
      slot(1, 0, 0, 2, 1'b1, 1'b0);
      #1;
      if (i == 31) begin
        check_eq("t5_last_pd", pd_of(1), 127);
      end
      tick();
    end
    clr();
    #1;
    check_eq("t5_empty", free_cnt, 0);
    slot(0, 0, 0, 4, 1'b1, 1'b0);
    #1;
    check_eq("t5_stall_rd", i_ready, 0);
    clr();
    slot(0, 1, 2, 0, 1'b0, 1'b0);
    #1;
    check_eq("t5_no_rd_ok", i_ready, 1);
    tick();
    clr();
    c_en     = 2'b01;
    c_old_pd = 14'd7;
    tick();
    clr();
    #1;
    check_eq("t5_free1", free_cnt, 1);
    slot(0, 0, 0, 8, 1'b1, 1'b0);
    slot(1, 0, 0, 9, 1'b1, 1'b0);
    #1;
    check_eq("t5_need2_stall", i_ready, 0);
    clr();
    slot(0, 0, 0, 9, 1'b1, 1'b0);
    #1;
    check_eq("t5_ready1", i_ready, 1);
    check_eq("t5_wrap_pd", pd_of(0), 7);
    tick();
    clr();
    #1;
    check_eq("t5_free0", free_cnt, 0);

    // Fill every checkpoint, stall, release the oldest.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr();
      slot(0, 0, 0, 0, 1'b0, 1'b1);
      #1;
      check_eq("t6_ready", i_ready, 1);
      check_eq("t6_ckpt_id", o_ckpt_id[1:0], i);
      if (i == 0) begin
        check_eq("t6_no_rd_pd", pd_of(0), 0);
        check_eq("t6_no_rd_old", old_of(0), 0);
      end
      tick();
    end
    clr();
    slot(0, 0, 0, 0, 1'b0, 1'b1);
    #1;
    check_eq("t6_full_stall", i_ready, 0);
    clr();
    c_br_ok = 1'b1;
    c_br_id = 2'd0;
    tick();
    clr();
    slot(0, 0, 0, 0, 1'b0, 1'b1);
    #1;
    check_eq("t6_ready_after", i_ready, 1);
    check_eq("t6_reuse_id0", o_ckpt_id[1:0], 0);
    tick();
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
